change_dispenser: RTL and testbench

- Downstream stage of the coin/timeout checker in the vending machine.
- When a return is triggered (wait-time expiry or explicit return), it latches the customer balance.
- It then emits change one coin per cycle on a one-hot coin bus, largest denomination first, until the balance is exhausted.
- It reports busy/done status and flags a balance that cannot be paid exactly.

---
 rtl/change_dispenser.sv | 129 ++++++++++++
 tb/tb_change_dispenser.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Downstream stage of the vending machine's coin/timeout checker. When a
// return is requested it latches the customer balance, then pays it out one
// coin per cycle, largest denomination first, until less than the smallest
// coin remains. Any non-zero residual that cannot be paid exactly is flagged
// on o_error and left visible on o_remaining.
//
// Ports:
//   clk            in   system clock, all state on rising edge
//   reset_n        in   synchronous, active-low reset
//   i_start        in   return request, sampled only while idle
//   i_balance      in   amount to return, sampled together with i_start
//   o_busy         out  high while a return is in progress
//   o_return_coin  out  one-hot coin this cycle: bit0=COIN0, bit1=COIN1,
//                       bit2=COIN2; zero means no coin
//   o_remaining    out  amount still owed
//   o_done         out  single-cycle pulse when dispensing finishes
//   o_error        out  unpayable residual remained; held until next accept
//
// All outputs are registered; nothing flows combinationally from inputs to
// outputs.
// -----------------------------------------------------------------------------
module change_dispenser #(
   parameter int BAL_W     = 32,
   parameter int COIN0_VAL = 100,
   parameter int COIN1_VAL = 500,
   parameter int COIN2_VAL = 1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic [BAL_W-1:0] i_balance,
   output logic             o_busy,
   output logic [2:0]       o_return_coin,
   output logic [BAL_W-1:0] o_remaining,
   output logic             o_done,
   output logic             o_error
);

   localparam logic [BAL_W-1:0] COIN0 = BAL_W'(COIN0_VAL);
   localparam logic [BAL_W-1:0] COIN1 = BAL_W'(COIN1_VAL);
   localparam logic [BAL_W-1:0] COIN2 = BAL_W'(COIN2_VAL);

   typedef enum logic {
      IDLE     = 1'b0,
      DISPENSE = 1'b1
   } state_t;

   state_t           state, state_next;
   logic             busy_next;
   logic [2:0]       coin_next;
   logic [BAL_W-1:0] remaining_next;
   logic             done_next;
   logic             error_next;

   // Next-state and next-output logic. The greedy choice is made from the
   // registered remaining amount, and each subtraction is guarded by its
   // compare, so the datapath can never underflow.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; that is what keeps this block free of inferred latches.
      state_next     = state;
      busy_next      = o_busy;
      coin_next      = 3'b000;
      remaining_next = o_remaining;
      done_next      = 1'b0;
      error_next     = o_error;

      unique case (state)
         IDLE: begin
            if (i_start) begin
               remaining_next = i_balance;
               error_next     = 1'b0;
               busy_next      = 1'b1;
               state_next     = DISPENSE;
            end
         end

         DISPENSE: begin
            if (o_remaining >= COIN2) begin
               coin_next      = 3'b100;
               remaining_next = o_remaining - COIN2;
            end else if (o_remaining >= COIN1) begin
               coin_next      = 3'b010;
               remaining_next = o_remaining - COIN1;
            end else if (o_remaining >= COIN0) begin
               coin_next      = 3'b001;
               remaining_next = o_remaining - COIN0;
            end else begin
               // Nothing more can be paid: finish, keep the residual visible.
               done_next  = 1'b1;
               busy_next  = 1'b0;
               error_next = (o_remaining != '0);
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset aborts any return in progress and
   // discards the residual.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!reset_n) begin
         state         <= IDLE;
         o_busy        <= 1'b0;
         o_return_coin <= 3'b000;
         o_remaining   <= '0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
      end else begin
         state         <= state_next;
         o_busy        <= busy_next;
         o_return_coin <= coin_next;
         o_remaining   <= remaining_next;
         o_done        <= done_next;
         o_error       <= error_next;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Self-checking bench for change_dispenser. A behavioural model plans each
// return as a list of coins using integer division, then plays that list out
// one coin per cycle; a compare process checks every DUT output against the
// model on each falling edge. Directed sequences add literal expectations,
// and a batch of random balances checks that the coins plus residual add up.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

   localparam int BAL_W = 32;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             i_start;
   logic [BAL_W-1:0] i_balance;
   logic             o_busy;
   logic [2:0]       o_return_coin;
   logic [BAL_W-1:0] o_remaining;
   logic             o_done;
   logic             o_error;

   int checks = 0;
   int errors = 0;

   change_dispenser #(
      .BAL_W    (BAL_W),
      .COIN0_VAL(100),
      .COIN1_VAL(500),
      .COIN2_VAL(1000)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_start      (i_start),
      .i_balance    (i_balance),
      .o_busy       (o_busy),
      .o_return_coin(o_return_coin),
      .o_remaining  (o_remaining),
      .o_done       (o_done),
      .o_error      (o_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual,
                  expected, $time);
      end
   endtask

   function automatic int coin_value(input logic [2:0] coin);
      case (coin)
         3'b001:  return 100;
         3'b010:  return 500;
         3'b100:  return 1000;
         default: return 0;
      endcase
   endfunction

   function automatic logic [2:0] coin_code(input int value);
      case (value)
         100:     return 3'b001;
         500:     return 3'b010;
         1000:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Behavioural model: a return is a pre-computed list of coins plus a
   // residual; each cycle pops one coin, and an empty list means "finish".
   // ---------------------------------------------------------------------------
   bit          model_live = 1'b0;
   bit          m_active   = 1'b0;
   int          m_plan[$];
   longint      m_residual;
   logic        e_busy, e_done, e_error;
   logic [2:0]  e_coin;
   longint      e_remaining;

   always @(posedge clk) begin
      if (!reset_n) begin
         model_live  = 1'b1;
         m_active    = 1'b0;
         m_plan.delete();
         e_busy      = 1'b0;
         e_coin      = 3'b000;
         e_remaining = 0;
         e_done      = 1'b0;
         e_error     = 1'b0;
      end else if (!m_active) begin
         e_coin = 3'b000;
         e_done = 1'b0;
         if (i_start) begin
            longint r;
            m_active    = 1'b1;
            e_busy      = 1'b1;
            e_error     = 1'b0;
            e_remaining = longint'(i_balance);
            r = longint'(i_balance);
            m_plan.delete();
            repeat (int'(r / 1000)) m_plan.push_back(1000);
            r = r % 1000;
            repeat (int'(r / 500)) m_plan.push_back(500);
            r = r % 500;
            repeat (int'(r / 100)) m_plan.push_back(100);
            m_residual = r % 100;
         end
      end else if (m_plan.size() > 0) begin
         int v;
         v           = m_plan.pop_front();
         e_coin      = coin_code(v);
         e_remaining = e_remaining - v;
         e_done      = 1'b0;
      end else begin
         m_active = 1'b0;
         e_coin   = 3'b000;
         e_done   = 1'b1;
         e_busy   = 1'b0;
         e_error  = (m_residual != 0);
      end
   end

   // Compare process: every output, every cycle, away from the active edge.
   always @(negedge clk) begin
      if (model_live) begin
         check("busy", o_busy, e_busy);
         check("coin", o_return_coin, e_coin);
         check("remaining", o_remaining, e_remaining[31:0]);
         check("done", o_done, e_done);
         check("error", o_error, e_error);
         check("onehot", ($countones(o_return_coin) <= 1), 1);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers. All return at a falling edge.
   // ---------------------------------------------------------------------------
   // Present a start for one edge; returns at the falling edge after E0.
   task automatic start(input int bal);
      @(negedge clk);
      i_start   = 1'b1;
      i_balance = bal;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Advance one cycle and compare coin/done against literal values.
   task automatic step(input string name, input logic [2:0] coin,
                       input logic done);
      @(negedge clk);
      check({name, "_coin"}, o_return_coin, coin);
      check({name, "_done"}, o_done, done);
   endtask

   // Wait (bounded) for o_done, summing coin values; then check the total.
   task automatic run_random(input int bal);
      int sum = 0;
      bit seen = 1'b0;
      start(bal);
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         sum += coin_value(o_return_coin);
         if (o_done) seen = 1'b1;
      end
      check("rand_done_seen", seen, 1);
      check("rand_sum", sum + o_remaining, bal);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n   = 1'b0;
      i_start   = 1'b0;
      i_balance = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", o_busy, 0);
      check("reset_coin", o_return_coin, 0);
      check("reset_remaining", o_remaining, 0);
      check("reset_done", o_done, 0);
      check("reset_error", o_error, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1600 -> 1000, 500, 100, then done.
      start(1600);
      check("b1600_busy_e0", o_busy, 1);
      check("b1600_rem_e0", o_remaining, 1600);
      step("b1600_e1", 3'b100, 1'b0);
      step("b1600_e2", 3'b010, 1'b0);
      step("b1600_e3", 3'b001, 1'b0);
      check("b1600_busy_e3", o_busy, 1);
      step("b1600_e4", 3'b000, 1'b1);
      check("b1600_busy_e4", o_busy, 0);
      check("b1600_rem_end", o_remaining, 0);
      check("b1600_err_end", o_error, 0);

      // Zero balance: done after E1, busy for exactly one cycle.
      start(0);
      check("b0_busy_e0", o_busy, 1);
      step("b0_e1", 3'b000, 1'b1);
      check("b0_busy_e1", o_busy, 0);
      check("b0_err", o_error, 0);

      // 2750 -> 1000, 1000, 500, 100, 100, residual 50 flagged.
      start(2750);
      step("b2750_e1", 3'b100, 1'b0);
      step("b2750_e2", 3'b100, 1'b0);
      step("b2750_e3", 3'b010, 1'b0);
      step("b2750_e4", 3'b001, 1'b0);
      step("b2750_e5", 3'b001, 1'b0);
      step("b2750_e6", 3'b000, 1'b1);
      check("b2750_rem", o_remaining, 50);
      check("b2750_err", o_error, 1);
      repeat (3) @(negedge clk);
      check("b2750_err_held", o_error, 1);
      start(1000);
      check("b1000_err_cleared", o_error, 0);
      step("b1000_e1", 3'b100, 1'b0);
      step("b1000_e2", 3'b000, 1'b1);

      // 3000 with a start request while busy: ignored.
      start(3000);
      i_start   = 1'b1;
      i_balance = 500;
      step("b3000_e1", 3'b100, 1'b0);
      i_start = 1'b0;
      step("b3000_e2", 3'b100, 1'b0);
      step("b3000_e3", 3'b100, 1'b0);
      step("b3000_e4", 3'b000, 1'b1);
      check("b3000_rem", o_remaining, 0);
      start(500);
      step("b500_e1", 3'b010, 1'b0);
      step("b500_e2", 3'b000, 1'b1);

      // Reset after the second coin of 5000 aborts the return.
      start(5000);
      step("b5000_e1", 3'b100, 1'b0);
      step("b5000_e2", 3'b100, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort_busy", o_busy, 0);
      check("abort_coin", o_return_coin, 0);
      check("abort_rem", o_remaining, 0);
      reset_n = 1'b1;
      repeat (3) step("abort_idle", 3'b000, 1'b0);
      start(1600);
      step("fresh_e1", 3'b100, 1'b0);
      step("fresh_e2", 3'b010, 1'b0);
      step("fresh_e3", 3'b001, 1'b0);
      step("fresh_e4", 3'b000, 1'b1);

      // Back-to-back: start held through the done cycle is accepted next edge.
      @(negedge clk);
      i_start   = 1'b1;
      i_balance = 600;
      @(negedge clk);
      step("b2b_e1", 3'b010, 1'b0);
      step("b2b_e2", 3'b001, 1'b0);
      step("b2b_e3", 3'b000, 1'b1);
      @(negedge clk);
      check("b2b_reaccept_busy", o_busy, 1);
      check("b2b_reaccept_rem", o_remaining, 600);
      i_start = 1'b0;
      step("b2b2_e1", 3'b010, 1'b0);
      step("b2b2_e2", 3'b001, 1'b0);
      step("b2b2_e3", 3'b000, 1'b1);

      // Random balances 0..20000 in steps of 50.
      for (int n = 0; n < 25; n++) begin
         run_random(int'($urandom_range(0, 400)) * 50);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
